// File: rtl/lb4_seq_ctrl.sv
// -----------------------------------------------------------------------------
// lb4_seq_ctrl
//
// Sequencer for a chain of NSLICE cascaded 4-bit loadable up/down counter
// slices. A run loads a start value into the slices, then counts towards the
// terminal value (all-ones when counting up, all-zeros when counting down).
// Counting stops exactly on the terminal value, so the counter never wraps.
// A shadow copy of the expected count is kept so the slice readback (Q) and
// the top-slice carry/borrow (CO) can be checked.
//
// Ports
//   CK     in   1  clock, rising edge
//   CD     in   1  synchronous active-high reset, highest priority
//   START  in   1  start a run (only honoured in IDLE)
//   DIR    in   1  1 = up, 0 = down (captured with START)
//   LDVAL  in   W  start value (captured with START)
//   ABORT  in   1  stop a run in LOAD or RUN, no DONE pulse
//   SD     out  1  slices: 1 = parallel load, 0 = count
//   SP     out  1  slices: clock enable
//   CI     out  1  lowest slice carry/borrow in
//   CON    out  1  slices: 1 = up, 0 = down
//   D      out  W  slices: parallel load data
//   CO     in   1  carry/borrow out of the top slice
//   Q      in   W  counter readback
//   BUSY   out  1  run active (LOAD, RUN, DONE)
//   DONE   out  1  one-cycle completion pulse
//   ERR    out  1  sticky readback/carry mismatch, cleared at next LOAD
// -----------------------------------------------------------------------------
module lb4_seq_ctrl #(
   parameter int    NSLICE = 4,
   parameter string CHECK  = "ENABLED"
) (
   input  logic                CK,
   input  logic                CD,
   input  logic                START,
   input  logic                DIR,
   input  logic [4*NSLICE-1:0] LDVAL,
   input  logic                ABORT,
   output logic                SD,
   output logic                SP,
   output logic                CI,
   output logic                CON,
   output logic [4*NSLICE-1:0] D,
   input  logic                CO,
   input  logic [4*NSLICE-1:0] Q,
   output logic                BUSY,
   output logic                DONE,
   output logic                ERR
);

   localparam int             W           = 4 * NSLICE;
   localparam logic [W-1:0]   LP_ONE      = W'(1);
   localparam bit             LP_CHECK_EN = (CHECK == "ENABLED");

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_DONE
   } state_t;

   // Registered state and outputs
   state_t       r_state;
   logic         r_sd;
   logic         r_sp;
   logic         r_dir;     // drives both CI and CON
   logic [W-1:0] r_d;       // latched LDVAL, also the LOAD-time shadow source
   logic [W-1:0] r_s;       // shadow of the expected counter value
   logic         r_busy;
   logic         r_done;
   logic         r_err;
   logic         r_first;   // first RUN cycle: readback compare skipped

   // Next-state values
   state_t       w_state_nxt;
   logic         w_sd_nxt;
   logic         w_sp_nxt;
   logic         w_dir_nxt;
   logic [W-1:0] w_d_nxt;
   logic [W-1:0] w_s_nxt;
   logic         w_busy_nxt;
   logic         w_done_nxt;
   logic         w_err_nxt;
   logic         w_first_nxt;

   logic [W-1:0] w_term;
   logic [W-1:0] w_s_step;

   assign w_term   = r_dir ? {W{1'b1}} : {W{1'b0}};
   assign w_s_step = r_dir ? (r_s + LP_ONE) : (r_s - LP_ONE);

   // Every output is computed here for the cycle that follows the next edge
   // and then registered, so SD/SP only ever change on a clock edge.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path can leave
      // one unassigned, which would otherwise infer a latch.
      w_state_nxt = r_state;
      w_sd_nxt    = 1'b0;
      w_sp_nxt    = 1'b0;
      w_dir_nxt   = r_dir;
      w_d_nxt     = r_d;
      w_s_nxt     = r_s;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      w_err_nxt   = r_err;
      w_first_nxt = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            // ABORT is irrelevant here: START with ABORT still starts a run.
            if (START) begin
               w_state_nxt = ST_LOAD;
               w_dir_nxt   = DIR;
               w_d_nxt     = LDVAL;
               w_sd_nxt    = 1'b1;
               w_sp_nxt    = 1'b1;
               w_busy_nxt  = 1'b1;
               w_err_nxt   = 1'b0;
            end
         end

         ST_LOAD: begin
            // The slices take D on this edge; the shadow follows.
            w_s_nxt = r_d;
            if (ABORT) begin
               w_state_nxt = ST_IDLE;
            end else if (r_d == w_term) begin
               // Already at the terminal value: no counts to perform.
               w_state_nxt = ST_DONE;
               w_busy_nxt  = 1'b1;
               w_done_nxt  = 1'b1;
            end else begin
               w_state_nxt = ST_RUN;
               w_sp_nxt    = 1'b1;
               w_busy_nxt  = 1'b1;
               w_first_nxt = 1'b1;
            end
         end

         ST_RUN: begin
            if (LP_CHECK_EN && !r_first && (Q != r_s)) begin
               w_err_nxt = 1'b1;
            end
            // SP is high this cycle, so the slices step on this edge.
            w_s_nxt = w_s_step;
            if (ABORT) begin
               w_state_nxt = ST_IDLE;
            end else if (w_s_step == w_term) begin
               // Drop SP now so the counter parks on the terminal value.
               w_state_nxt = ST_DONE;
               w_busy_nxt  = 1'b1;
               w_done_nxt  = 1'b1;
            end else begin
               w_sp_nxt    = 1'b1;
               w_busy_nxt  = 1'b1;
            end
         end

         ST_DONE: begin
            // Up: carry out is 1 at all-ones. Down: borrow out is 0 at zero.
            if ((CO != r_dir) || (LP_CHECK_EN && (Q != r_s))) begin
               w_err_nxt = 1'b1;
            end
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CK) begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples the values from before the edge, independent of statement order.
      if (CD) begin
         r_state <= ST_IDLE;
         r_sd    <= 1'b0;
         r_sp    <= 1'b0;
         r_dir   <= 1'b0;
         r_d     <= '0;
         r_s     <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_first <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_sd    <= w_sd_nxt;
         r_sp    <= w_sp_nxt;
         r_dir   <= w_dir_nxt;
         r_d     <= w_d_nxt;
         r_s     <= w_s_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_err   <= w_err_nxt;
         r_first <= w_first_nxt;
      end
   end

   assign SD   = r_sd;
   assign SP   = r_sp;
   assign CI   = r_dir;
   assign CON  = r_dir;
   assign D    = r_d;
   assign BUSY = r_busy;
   assign DONE = r_done;
   assign ERR  = r_err;

endmodule

// File: tb/tb_lb4_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lb4_seq_ctrl
//
// Bench for lb4_seq_ctrl. A behavioural model of the counter slices sits on
// the DUT outputs and feeds Q/CO back. For each run the expected per-cycle
// trace of outputs is derived from the count arithmetic (load, N counts,
// DONE, idle) and a single compare process checks the DUT against it on the
// falling edge of every cycle.
// -----------------------------------------------------------------------------
module tb_lb4_seq_ctrl;

   localparam int           NS   = 4;
   localparam int           W    = 4 * NS;
   localparam logic [W-1:0] ALL1 = '1;
   localparam logic [W-1:0] ONE  = W'(1);

   logic         CK    = 1'b0;
   logic         CD    = 1'b1;
   logic         START = 1'b0;
   logic         DIR   = 1'b0;
   logic         ABORT = 1'b0;
   logic [W-1:0] LDVAL = '0;
   logic         SD, SP, CI, CON, CO, BUSY, DONE, ERR;
   logic [W-1:0] D, Q;

   logic [W-1:0] cnt     = '0;   // true counter contents
   logic         fault_q = 1'b0; // Q bit 0 stuck at 0 when set

   int n_checks = 0;
   int n_errors = 0;

   typedef struct packed {
      logic         sd;
      logic         sp;
      logic         ci;
      logic         con;
      logic [W-1:0] d;
      logic         busy;
      logic         done;
      logic         err;
      logic [W-1:0] q;
   } exp_t;

   exp_t         exp_cur;
   exp_t         trace[$];
   bit           chk_on = 1'b0;
   logic [W-1:0] q_hold = '0;

   lb4_seq_ctrl #(.NSLICE(NS), .CHECK("ENABLED")) dut (
      .CK   (CK),
      .CD   (CD),
      .START(START),
      .DIR  (DIR),
      .LDVAL(LDVAL),
      .ABORT(ABORT),
      .SD   (SD),
      .SP   (SP),
      .CI   (CI),
      .CON  (CON),
      .D    (D),
      .CO   (CO),
      .Q    (Q),
      .BUSY (BUSY),
      .DONE (DONE),
      .ERR  (ERR)
   );

   always #5 CK = ~CK;

   // Counter slice chain: load, or step when the carry/borrow-in enables it.
   always @(posedge CK) begin
      if (SP) begin
         if (SD) cnt <= D;
         else if (CON ? CI : !CI) cnt <= CON ? (cnt + ONE) : (cnt - ONE);
      end
   end
   assign Q  = fault_q ? (cnt & ~ONE) : cnt;
   assign CO = CON ? (cnt == ALL1) : (cnt != '0);

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
      end
   endtask

   always @(negedge CK) begin
      if (chk_on) begin
         check("SD",   W'(SD),   W'(exp_cur.sd));
         check("SP",   W'(SP),   W'(exp_cur.sp));
         check("CI",   W'(CI),   W'(exp_cur.ci));
         check("CON",  W'(CON),  W'(exp_cur.con));
         check("D",    D,        exp_cur.d);
         check("BUSY", W'(BUSY), W'(exp_cur.busy));
         check("DONE", W'(DONE), W'(exp_cur.done));
         check("ERR",  W'(ERR),  W'(exp_cur.err));
         check("Q",    cnt,      exp_cur.q);
      end
   end

   function automatic exp_t mk(input logic sd, input logic sp, input logic ci, input logic con,
                               input logic [W-1:0] d, input logic busy, input logic done,
                               input logic err, input logic [W-1:0] q);
      exp_t e;
      e.sd = sd; e.sp = sp; e.ci = ci; e.con = con; e.d = d;
      e.busy = busy; e.done = done; e.err = err; e.q = q;
      return e;
   endfunction

   function automatic logic [W-1:0] seen(input logic [W-1:0] v, input bit f);
      return f ? (v & ~ONE) : v;
   endfunction

   // Expected trace starting with the LOAD cycle: LOAD, N RUN cycles
   // (N = counts to terminal), DONE, then two idle cycles. A stop index
   // (abort or reset) truncates the run at that cycle.
   task automatic build_trace(input logic [W-1:0] ld, input logic dir, input int abort_at,
                              input int rst_at, input bit fault, input logic [W-1:0] q_prev);
      int           n;
      logic [W-1:0] q;
      bit           err;
      bit           stopped;
      bit           by_rst;
      trace.delete();
      n       = dir ? int'(ALL1 - ld) : int'(ld);
      err     = 1'b0;
      stopped = (abort_at == 0) || (rst_at == 0);
      by_rst  = (rst_at == 0);
      trace.push_back(mk(1'b1, 1'b1, dir, dir, ld, 1'b1, 1'b0, 1'b0, q_prev));
      q = ld;
      if (!stopped) begin
         for (int i = 1; i <= n; i++) begin
            trace.push_back(mk(1'b0, 1'b1, dir, dir, ld, 1'b1, 1'b0, err, q));
            if (i >= 2 && seen(q, fault) != q) err = 1'b1;
            q = dir ? (q + ONE) : (q - ONE);
            if (i == abort_at || i == rst_at) begin
               stopped = 1'b1;
               by_rst  = (i == rst_at);
               break;
            end
         end
         if (!stopped) begin
            trace.push_back(mk(1'b0, 1'b0, dir, dir, ld, 1'b1, 1'b1, err, q));
            if (seen(q, fault) != q) err = 1'b1;
         end
      end
      for (int k = 0; k < 2; k++) begin
         if (by_rst) trace.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, q));
         else        trace.push_back(mk(1'b0, 1'b0, dir, dir, ld, 1'b0, 1'b0, err, q));
      end
   endtask

   // noise: START with junk DIR/LDVAL while busy, ABORT in DONE and idle.
   task automatic do_op(input logic [W-1:0] ld, input logic dir, input int abort_at,
                        input int rst_at, input bit fault, input bit noise, input bit start_abort);
      build_trace(ld, dir, abort_at, rst_at, fault, q_hold);
      START   = 1'b1;
      DIR     = dir;
      LDVAL   = ld;
      ABORT   = start_abort;
      fault_q = fault;
      foreach (trace[j]) begin
         @(posedge CK); #1;
         exp_cur = trace[j];
         START   = noise && trace[j].busy;
         LDVAL   = START ? W'($urandom) : ld;
         DIR     = START ? 1'($urandom) : dir;
         ABORT   = (j == abort_at) || (noise && !(trace[j].busy && !trace[j].done));
         CD      = (j == rst_at);
      end
      q_hold = trace[trace.size()-1].q;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (2) @(posedge CK);
      #1;
      check("rst_SD",   W'(SD),   '0);
      check("rst_SP",   W'(SP),   '0);
      check("rst_CI",   W'(CI),   '0);
      check("rst_CON",  W'(CON),  '0);
      check("rst_D",    D,        '0);
      check("rst_BUSY", W'(BUSY), '0);
      check("rst_DONE", W'(DONE), '0);
      check("rst_ERR",  W'(ERR),  '0);
      CD      = 1'b0;
      exp_cur = mk(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
      chk_on  = 1'b1;
      @(posedge CK); #1;

      // Up run FFFC: three increments, DONE between edges 4 and 5.
      do_op(16'hFFFC, 1'b1, -1, -1, 1'b0, 1'b0, 1'b0);
      check("pin_up_len",   W'(trace.size()), W'(7));
      check("pin_up_run3",  trace[3].q,       16'hFFFE);
      check("pin_up_done",  W'(trace[4].done), W'(1));
      check("up_q_final",   cnt,              16'hFFFF);

      // Down run 0002 with START/ABORT noise that must be ignored.
      do_op(16'h0002, 1'b0, -1, -1, 1'b0, 1'b1, 1'b0);
      check("pin_dn_len",   W'(trace.size()), W'(6));
      check("dn_q_final",   cnt,              16'h0000);

      // Zero-count runs.
      do_op(16'hFFFF, 1'b1, -1, -1, 1'b0, 1'b0, 1'b0);
      check("pin_zero_len", W'(trace.size()), W'(4));
      check("pin_zero_sp",  W'(trace[1].sp),   W'(0));
      check("zero_q",       cnt,              16'hFFFF);
      do_op(16'h0000, 1'b0, -1, -1, 1'b0, 1'b0, 1'b0);

      // Abort in the third RUN cycle, then abort in LOAD.
      do_op(16'h0100, 1'b1, 3, -1, 1'b0, 1'b0, 1'b0);
      check("abort_q",      cnt,              16'h0103);
      do_op(16'h0050, 1'b0, 0, -1, 1'b0, 1'b0, 1'b0);
      check("abort_load_q", cnt,              16'h0050);

      // Reset in the second RUN cycle of a down run.
      do_op(16'h0020, 1'b0, -1, 2, 1'b0, 1'b0, 1'b0);
      check("rst_run_q",    cnt,              16'h001E);

      // Q bit 0 stuck at 0 during an up run from 0010.
      do_op(16'h0010, 1'b1, 5, -1, 1'b1, 1'b0, 1'b0);
      check("fault_err",    W'(ERR),          W'(1));

      // START with ABORT in IDLE starts a run and clears ERR in LOAD.
      do_op(16'hFFE0, 1'b1, -1, -1, 1'b0, 1'b1, 1'b1);
      check("clear_err",    W'(ERR),          W'(0));
      do_op(16'h0040, 1'b0, -1, -1, 1'b0, 1'b1, 1'b0);

      chk_on = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/lb4_seq_ctrl.md
LB4_SEQ_CTRL -- requirements
Module: lb4_seq_ctrl

Interface
REQ-001 Parameter: NSLICE, 4, number of cascaded 4-bit loadable up/down counter slices driven; count width W = 4*NSLICE.
REQ-002 Parameter: CHECK, "ENABLED", "ENABLED" turns on readback compare of Q against the shadow count; "DISABLED" forces the compare result to "no mismatch".
REQ-003 One clock; reset is synchronous and active-high. Clock port is CK and reset port is CD.
REQ-004 CK  input  1  clock; all state updates on rising edge.
REQ-005 CD  input  1  synchronous active-high reset; highest priority.
REQ-006 START  input  1  request a count run; sampled only in IDLE.
REQ-007 DIR  input  1  1 = count up, 0 = count down; sampled with START.
REQ-008 LDVAL  input  W  start value; sampled with START.
REQ-009 ABORT  input  1  terminates LOAD or RUN.
REQ-010 SD  output  1  to slices: 1 = parallel load, 0 = count.
REQ-011 SP  output  1  to slices: clock enable.
REQ-012 CI  output  1  to lowest slice: carry/borrow in.
REQ-013 CON  output  1  to all slices: 1 = up, 0 = down.
REQ-014 D  output  W  to slices: parallel load data.
REQ-015 CO  input  1  carry/borrow out of top slice.
REQ-016 Q  input  W  counter readback.
REQ-017 BUSY, DONE, ERR  output  1 each  status: run active, one-cycle completion pulse, sticky mismatch.

Function
REQ-018 States SHALL be IDLE, LOAD, RUN, DONE; every output SHALL be registered.
REQ-019 IDLE: SP=0, SD=0, BUSY=0. START=1 SHALL latch DIR, LDVAL and enter LOAD.
REQ-020 LOAD: SD=1, SP=1, D=LDVAL, CON=DIR, CI=DIR, BUSY=1, ERR cleared. The shadow count S SHALL load LDVAL at the exiting edge.
REQ-021 Terminal value T SHALL be all-ones when DIR=1 and all-zeros when DIR=0.
REQ-022 LOAD SHALL exit to DONE if LDVAL==T (zero counts performed); otherwise it SHALL exit to RUN.
REQ-023 RUN: SD=0, SP=1, CI=DIR, CON=DIR. Each edge SHALL update S to S+1 (up) or S-1 (down), mod 2^W.
REQ-024 The edge at which the next S equals T SHALL move RUN to DONE with SP=0, so the counter holds at T without wrapping.
REQ-025 Counts performed SHALL be (2^W-1)-LDVAL when up and LDVAL when down.
REQ-026 DONE: SP=0, DONE=1 for exactly one cycle, BUSY=1; the next state SHALL be IDLE.
REQ-027 In DONE, CO SHALL equal DIR (up: carry 1 at all-ones; down: borrow 0 at all-zeros); any other CO value SHALL set ERR.
REQ-028 With CHECK="ENABLED", Q!=S during RUN (from the second RUN cycle) or during DONE SHALL set ERR.
REQ-029 ERR SHALL stay set until the next LOAD or CD.
REQ-030 ABORT in LOAD or RUN SHALL go to IDLE on the next edge with SP=0 and no DONE pulse; the counter holds its value. ABORT in IDLE or DONE SHALL be ignored.
REQ-031 START while not in IDLE SHALL be ignored. START and ABORT together in IDLE SHALL start a run.
REQ-032 SD and SP SHALL never change mid-cycle; D SHALL hold the latched LDVAL from LOAD until the next START.

Reset
REQ-033 CD=1 at an edge SHALL force IDLE and set SD=0, SP=0, CI=0, CON=0, D=0, S=0, BUSY=0, DONE=0, ERR=0, overriding all states including mid-run.

Verification
REQ-034 Up run: W=16, START with DIR=1, LDVAL=FFFC at edge 0 -> LOAD in cycle 1, Q=FFFD/FFFE/FFFF after edges 2/3/4, DONE=1 only between edges 4 and 5, CO=1, ERR=0, Q holds FFFF.
REQ-035 Down run: DIR=0, LDVAL=0002 -> two decrements, Q=0000, DONE one cycle, CO=0, ERR=0.
REQ-036 Zero-count run: DIR=1, LDVAL=FFFF -> LOAD then DONE, SP=0 throughout DONE, Q=FFFF, no increment.
REQ-037 Abort and reset: ABORT during the third RUN cycle -> IDLE, no DONE, Q frozen. CD mid-RUN -> all outputs return to their reset values at the next edge.
REQ-038 Fault injection: force Q bit 0 stuck at 0 during an up run from 0010 -> ERR set and held through IDLE, then cleared at the next LOAD. START pulses while BUSY=1 have no effect.
